// File: rtl/btn_event_gen_pkg.sv
// Shared state encodings, 27 MHz timing defaults and a small width helper
// for the button event generator.
package btn_event_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 270000;    // 10 ms
  localparam int DEF_REPEAT_DELAY    = 13500000;  // 0.5 s
  localparam int DEF_REPEAT_PERIOD   = 2700000;   // 100 ms
  localparam int DEF_ACTIVE_LOW      = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; both flops
// load RST_VAL on reset so the downstream logic sees a known idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/btn_event_gen.sv
// Debounces one raw push-button and emits single-cycle press, release and
// auto-repeat pulses plus a registered debounced "held" level.
module btn_event_gen
  import btn_event_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD,
  parameter int ACTIVE_LOW      = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic held,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam bit REP_EN = (REPEAT_DELAY > 0);
  localparam logic [CW-1:0] DB_TERM  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] DLY_TERM = CW'(REP_EN ? REPEAT_DELAY - 1 : 0);
  localparam logic [CW-1:0] PER_TERM = CW'(REPEAT_PERIOD - 1);

  logic          w_sync;
  logic          w_p;
  btn_state_t    r_state;
  btn_state_t    w_state_nxt;
  logic [CW-1:0] r_db_cnt;
  logic [CW-1:0] r_rep_cnt;
  logic          r_rep_phase;
  logic          r_held;
  logic          w_press;
  logic          w_release;
  logic          w_repeat;
  logic          w_rep_term;

  // Reset value is the released pin level, so reset never looks like a press.
  sync_2ff #(
    .RST_VAL (ACTIVE_LOW != 0)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (btn_raw),
    .o_q (w_sync)
  );

  assign w_p = (ACTIVE_LOW != 0) ? ~w_sync : w_sync;

  assign w_rep_term = r_rep_phase ? (r_rep_cnt == PER_TERM) : (r_rep_cnt == DLY_TERM);

  always_comb begin
    w_state_nxt = r_state;
    w_press     = 1'b0;
    w_release   = 1'b0;
    w_repeat    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_p) w_state_nxt = ST_PRESS_WAIT;
      end
      ST_PRESS_WAIT: begin
        if (!w_p) begin
          w_state_nxt = ST_IDLE;
        end else if (r_db_cnt == DB_TERM) begin
          w_state_nxt = ST_HELD;
          w_press     = 1'b1;
        end
      end
      ST_HELD: begin
        w_repeat = REP_EN && w_rep_term;
        if (!w_p) w_state_nxt = ST_RELEASE_WAIT;
      end
      ST_RELEASE_WAIT: begin
        if (w_p) begin
          w_state_nxt = ST_HELD;
        end else if (r_db_cnt == DB_TERM) begin
          w_state_nxt = ST_IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Debounce counter restarts on every state change; terminal count always leaves the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_db_cnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_db_cnt <= '0;
    end else if (r_state == ST_PRESS_WAIT || r_state == ST_RELEASE_WAIT) begin
      r_db_cnt <= r_db_cnt + 1'b1;
    end
  end

  // Repeat timer only advances in HELD, so a bounce into RELEASE_WAIT freezes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_press) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (REP_EN && r_state == ST_HELD) begin
      if (w_rep_term) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b1;
      end else begin
        r_rep_cnt   <= r_rep_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)            r_held <= 1'b0;
    else if (w_press)   r_held <= 1'b1;
    else if (w_release) r_held <= 1'b0;
  end

  assign held          = r_held;
  assign press_pulse   = w_press;
  assign release_pulse = w_release;
  assign repeat_pulse  = w_repeat;

endmodule
